// File: rtl/count_seq_pkg.sv
// Shared types and constants for the count sequencer.
// Used by count_sequencer and seq_cycle_timer.
package count_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRE,
        S_WAIT_TC,
        S_SETTLE,
        S_FINISH
    } seq_state_t;

    localparam int TIMEOUT_CYC_DEF = 65540;
    localparam int SETTLE_CYC      = 2;
    localparam int TMR_W           = 17;

endpackage

// File: rtl/seq_cycle_timer.sv
// Cycle counter for the en_out-to-tc_in wait; expires at LIMIT elapsed cycles.
// Holds its value when neither cleared nor enabled.
module seq_cycle_timer #(
    parameter int W     = 17,
    parameter int LIMIT = 65540
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_clear,
    input  logic         i_enable,
    output logic [W-1:0] o_count,
    output logic         o_expired
);

    // count lags elapsed cycles by one, since it is cleared in the pulse cycle
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count   = r_count;
    assign o_expired = (r_count >= LAST);

endmodule

// File: rtl/count_sequencer.sv
// Fires a downstream counter num_runs times, waiting for tc_in each run.
// Define COUNT_SEQ_PERIOD_EN to add the last_period measurement output.
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int RUNS_W      = 8,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [RUNS_W-1:0] num_runs,
    input  logic              tc_in,
    output logic              en_out,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [RUNS_W-1:0] runs_done
`ifdef COUNT_SEQ_PERIOD_EN
    ,
    output logic [TMR_W-1:0]  last_period
`endif
);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic              r_en;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [RUNS_W-1:0] r_runs_done;
    logic [RUNS_W-1:0] r_target;
    logic [1:0]        r_settle;
    logic              w_accept;
    logic              w_zero_req;
    logic              w_tc_hit;
    logic              w_timeout;
    logic [TMR_W-1:0]  w_count;
    logic              w_expired;

    seq_cycle_timer #(
        .W     (TMR_W),
        .LIMIT (TIMEOUT_CYC)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (r_state == S_FIRE),
        .i_enable  (r_state == S_WAIT_TC),
        .o_count   (w_count),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_zero_req  = 1'b0;
        w_tc_hit    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && (num_runs != '0)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_FIRE;
                end else if (start) begin
                    w_zero_req = 1'b1;
                end
            end
            S_FIRE: w_state_nxt = S_WAIT_TC;
            S_WAIT_TC: begin
                if (tc_in) begin
                    w_tc_hit    = 1'b1;
                    w_state_nxt = S_SETTLE;
                end else if (w_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_FINISH;
                end
            end
            S_SETTLE: begin
                // leave only after tc_in has been low for SETTLE_CYC+1 cycles
                if (!tc_in && (r_settle == 2'(SETTLE_CYC))) begin
                    w_state_nxt = (r_runs_done < r_target) ? S_FIRE : S_FINISH;
                end
            end
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_en        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_runs_done <= '0;
            r_target    <= '0;
            r_settle    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_en    <= (w_state_nxt == S_FIRE);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_FINISH) || w_zero_req;
            if (w_accept) begin
                r_target    <= num_runs;
                r_runs_done <= '0;
                r_err       <= 1'b0;
            end else if (w_zero_req) begin
                r_runs_done <= '0;
            end else if (w_tc_hit && (r_runs_done < r_target)) begin
                r_runs_done <= r_runs_done + RUNS_W'(1);
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (r_state == S_WAIT_TC) begin
                r_settle <= '0;
            end else if (r_state == S_SETTLE) begin
                if (tc_in) begin
                    r_settle <= '0;
                end else if (r_settle != 2'(SETTLE_CYC)) begin
                    r_settle <= r_settle + 2'd1;
                end
            end
        end
    end

`ifdef COUNT_SEQ_PERIOD_EN
    logic [TMR_W-1:0] r_last_period;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_period <= '0;
        end else if (w_tc_hit) begin
            r_last_period <= w_count + TMR_W'(1);
        end
    end

    assign last_period = r_last_period;
`else
    logic w_unused_count;
    assign w_unused_count = ^w_count;
`endif

    assign en_out      = r_en;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout_err = r_err;
    assign runs_done   = r_runs_done;

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer with a reduced timeout.
// Define COUNT_SEQ_PERIOD_EN to also check last_period.
module tb_count_sequencer;

    localparam int TO = 200;

    typedef struct {
        int en;
        int runs;
        int err;
        int delta;
        int busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] num_runs;
    logic       tc_in;
    logic       en_out;
    logic       busy;
    logic       done;
    logic       timeout_err;
    logic [7:0] runs_done;
`ifdef COUNT_SEQ_PERIOD_EN
    logic [16:0] last_period;
`endif

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   en_cnt = 0;
    int   first_en = -1;
    int   model_on = 0;
    int   tc_dly = 0;

    count_sequencer #(
        .RUNS_W      (8),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .num_runs    (num_runs),
        .tc_in       (tc_in),
        .en_out      (en_out),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .runs_done   (runs_done)
`ifdef COUNT_SEQ_PERIOD_EN
        ,
        .last_period (last_period)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int en, input int runs, input int err,
                        input int delta, input int bsy);
        exp_t e;
        e.en = en;
        e.runs = runs;
        e.err = err;
        e.delta = delta;
        e.busy = bsy;
        q.push_back(e);
    endtask

    task automatic do_start(input int n);
        @(posedge clk);
        #1;
        start = 1'b1;
        num_runs = 8'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max);
        int k = 0;
        while (q.size() != 0 && k < max) begin
            @(posedge clk);
            k++;
        end
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: timed out with %0d pending, required 0",
                     name, q.size());
            q.delete();
        end
    endtask

    // downstream counter model: one tc_in pulse tc_dly cycles after en_out
    initial begin
        tc_in = 1'b0;
        forever begin
            @(negedge clk);
            if (en_out && model_on != 0) begin
                repeat (tc_dly) @(posedge clk);
                #1 tc_in = 1'b1;
                @(posedge clk);
                #1 tc_in = 1'b0;
            end
        end
    end

    // monitor: pops an expectation on every done pulse
    initial begin
        exp_t e;
        int d;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                en_cnt = 0;
                first_en = -1;
            end else begin
                if (en_out) begin
                    en_cnt++;
                    if (first_en < 0) first_en = cyc;
                end
                if (done) begin
                    if (q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_done: got done=1 required 0");
                    end else begin
                        e = q.pop_front();
                        d = (first_en < 0) ? 0 : cyc - first_en;
                        chk("done_en_pulses", en_cnt, e.en);
                        chk("done_runs_done", int'(runs_done), e.runs);
                        chk("done_timeout_err", int'(timeout_err), e.err);
                        chk("done_latency", d, e.delta);
                        chk("done_busy", int'(busy), e.busy);
                    end
                    en_cnt = 0;
                    first_en = -1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset_n = 1'b0;
        start = 1'b0;
        num_runs = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en_out", int'(en_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_timeout_err", int'(timeout_err), 0);
        chk("rst_runs_done", int'(runs_done), 0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // three runs, tc_in just inside the timeout window
        model_on = 1;
        tc_dly = TO - 6;
        push(3, 3, 0, 3 * (TO - 6 + 4), 1);
        do_start(3);
        wait_drain("three_runs", 2000);

        // no tc_in at all: timeout aborts after the first run
        model_on = 0;
        push(1, 0, 1, TO + 1, 1);
        do_start(2);
        wait_drain("timeout", 1000);

        // zero runs: immediate done, nothing fired, never busy
        push(0, 0, 1, 0, 0);
        do_start(0);
        #1;
        chk("zero_busy", int'(busy), 0);
        chk("zero_done_next", int'(done), 1);
        wait_drain("zero_runs", 20);

        // start while busy is dropped; stray tc_in in IDLE is ignored
        model_on = 1;
        tc_dly = 50;
        push(2, 2, 0, 2 * 54, 1);
        do_start(2);
        repeat (10) @(posedge clk);
        do_start(5);
        wait_drain("busy_start", 500);
        repeat (3) @(posedge clk);
        model_on = 0;
        #1 tc_in = 1'b1;
        @(posedge clk);
        #1 tc_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("stray_en_pulses", en_cnt, 0);
        chk("stray_runs_done", int'(runs_done), 2);
        chk("stray_busy", int'(busy), 0);

        // reset during the second of four runs
        model_on = 1;
        tc_dly = 50;
        do_start(4);
        k = 0;
        while (en_cnt < 2 && k < 400) begin
            @(posedge clk);
            k++;
        end
        chk("second_run_reached", (en_cnt >= 2) ? 1 : 0, 1);
        repeat (5) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("abort_en_out", int'(en_out), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_timeout_err", int'(timeout_err), 0);
        chk("abort_runs_done", int'(runs_done), 0);
        repeat (60) @(posedge clk);
        #3 reset_n = 1'b1;

        // first start after reset completes one normal run
        tc_dly = 100;
        push(1, 1, 0, 104, 1);
        do_start(1);
        wait_drain("after_reset", 500);
`ifdef COUNT_SEQ_PERIOD_EN
        #1;
        chk("last_period", int'(last_period), 100);
`endif
        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
